// File: rtl/set_job_sched.sv
// Round-robin front end sharing one SET candidate-counting core between NREQ
// requesters; latches job fields, runs the en/busy/valid handshake, watchdogs WAIT.
module set_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*24-1:0] req_central,
  input  logic [NREQ*12-1:0] req_radius,
  input  logic [NREQ*2-1:0]  req_mode,
  output logic [NREQ-1:0]    req_ack,
  output logic               set_en,
  output logic [23:0]        set_central,
  output logic [11:0]        set_radius,
  output logic [1:0]         set_mode,
  input  logic               set_busy,
  input  logic               set_valid,
  input  logic [7:0]         set_candidate,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_id,
  output logic [7:0]         resp_candidate,
  output logic               resp_err,
  output logic [15:0]        jobs_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_rr_ptr;
  logic [TO_W-1:0] r_wdog;

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [1:0]        w_off;
  logic [2:0]        w_sum;
  logic [1:0]        w_gnt;
  logic [23:0]       w_cen;
  logic [11:0]       w_rad;
  logic [1:0]        w_mode;
  logic              w_start;
  logic              w_timeout;

  // Rotate requests so bit 0 is the requester at rr_ptr, then map the offset back.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_rr_ptr +: NREQ];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 2'(k);
    end
  end

  assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_gnt = (w_sum >= 3'(NREQ)) ? 2'(w_sum - 3'(NREQ)) : w_sum[1:0];

  always_comb begin
    w_cen  = '0;
    w_rad  = '0;
    w_mode = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt == 2'(k)) begin
        w_cen  = req_central[24*k +: 24];
        w_rad  = req_radius[12*k +: 12];
        w_mode = req_mode[2*k +: 2];
      end
    end
  end

  assign w_start   = (r_state == IDLE) && (|req) && !set_busy;
  assign w_timeout = (r_wdog == TO_W'(TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (set_valid || w_timeout) w_next = DONE;
      DONE:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_wdog         <= '0;
      set_central    <= '0;
      set_radius     <= '0;
      set_mode       <= '0;
      resp_id        <= '0;
      resp_candidate <= '0;
      resp_err       <= 1'b0;
      jobs_done      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            set_central <= w_cen;
            set_radius  <= w_rad;
            set_mode    <= w_mode;
            resp_id     <= w_gnt;
          end
        end
        ISSUE: begin
          r_wdog   <= '0;
          r_rr_ptr <= (resp_id == 2'(NREQ - 1)) ? 2'd0 : resp_id + 2'd1;
        end
        WAIT: begin
          // A result on the timeout edge still counts as a good result.
          if (set_valid) begin
            resp_candidate <= set_candidate;
            resp_err       <= 1'b0;
          end else if (w_timeout) begin
            resp_candidate <= '0;
            resp_err       <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) jobs_done <= jobs_done + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign set_en     = (r_state == ISSUE);
  assign req_ack    = set_en ? (NREQ'(1) << resp_id) : '0;
  assign resp_valid = (r_state == DONE);

endmodule

// File: tb/tb_set_job_sched.sv
// Randomised bench for set_job_sched with a round-robin reference model and a
// behavioural core that answers a programmable number of cycles after set_en.
module tb_set_job_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [95:0] req_central;
  logic [47:0] req_radius;
  logic [7:0]  req_mode;
  logic [3:0]  req_ack;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_candidate;
  logic        resp_err;
  logic [15:0] jobs_done;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] f_cen [4];
  logic [11:0] f_rad [4];
  logic [1:0]  f_mode[4];
  int          m_ptr;
  int          m_jobs;

  int          core_lat;
  logic [7:0]  core_cand;
  int          core_cnt = 0;
  logic [7:0]  core_cand_l;

  always #5 clk = ~clk;

  set_job_sched #(.NREQ(4), .TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_central(req_central),
    .req_radius(req_radius), .req_mode(req_mode), .req_ack(req_ack),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_candidate(resp_candidate),
    .resp_err(resp_err), .jobs_done(jobs_done)
  );

  // Core: result strobe core_lat cycles after set_en (0 = never answers).
  always @(negedge clk) begin
    set_valid     = 1'b0;
    set_candidate = 8'($urandom);
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        set_valid     = 1'b1;
        set_candidate = core_cand_l;
      end
    end
    if (set_en === 1'b1) begin
      core_cnt    = core_lat;
      core_cand_l = core_cand;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < 4; i++) begin
      req_central[24*i +: 24] = f_cen[i];
      req_radius[12*i +: 12]  = f_rad[i];
      req_mode[2*i +: 2]      = f_mode[i];
    end
  endtask

  // One complete job: grant, ISSUE pulse, core answer, optional backpressure, accept.
  task automatic serve(input int lat, input logic [7:0] cand, input int bp,
                       input logic drop_g, input logic [3:0] drop_x, output int g);
    int n, ge, ecyc;
    logic e_err;
    logic [7:0] e_cand;
    logic [37:0] e_fld;
    core_lat  = lat;
    core_cand = cand;
    n = 0;
    while (req_ack === 4'b0 && n < 40) begin @(negedge clk); n++; end
    g = -1;
    for (int i = 0; i < 4; i++) if (req_ack[i] === 1'b1) g = i;
    ge = rr_pick(req, m_ptr);
    n_vec++;
    if (ge < 0 || req_ack !== (4'b0001 << ge) || set_en !== 1'b1) begin
      n_err++;
      $display("FAIL grant: req_ack=%b set_en=%b, expected ack of requester %0d with set_en=1", req_ack, set_en, ge);
    end
    if (ge < 0) ge = 0;
    e_fld = {f_cen[ge], f_rad[ge], f_mode[ge]};
    n_vec++;
    if ({set_central, set_radius, set_mode} !== e_fld) begin
      n_err++;
      $display("FAIL job_fields: got %h, expected %h", {set_central, set_radius, set_mode}, e_fld);
    end
    if (drop_g) req[ge] = 1'b0;
    req    = req & ~drop_x;
    m_ptr  = (ge + 1) % 4;
    e_err  = (lat == 0 || lat > 16);
    ecyc   = e_err ? 17 : lat + 1;
    e_cand = e_err ? 8'h00 : cand;
    @(negedge clk);
    n_vec++;
    if (req_ack !== 4'b0 || set_en !== 1'b0) begin
      n_err++;
      $display("FAIL ack_pulse_width: req_ack=%b set_en=%b one cycle after grant, expected 0", req_ack, set_en);
    end
    n = 1;
    while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_vec++;
    if (n !== ecyc) begin
      n_err++;
      $display("FAIL resp_latency: resp_valid after %0d cycles, expected %0d", n, ecyc);
    end
    n_vec++;
    if (resp_valid !== 1'b1 || resp_id !== 2'(ge) || resp_candidate !== e_cand || resp_err !== e_err) begin
      n_err++;
      $display("FAIL response: valid=%b id=%0d cand=%h err=%b, expected 1/%0d/%h/%b",
               resp_valid, resp_id, resp_candidate, resp_err, ge, e_cand, e_err);
    end
    n_vec++;
    if ({set_central, set_radius, set_mode} !== e_fld) begin
      n_err++;
      $display("FAIL fields_stable: got %h, expected %h", {set_central, set_radius, set_mode}, e_fld);
    end
    if (bp > 0) begin
      resp_ready = 1'b0;
      repeat (bp) begin
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 2'(ge) || resp_candidate !== e_cand ||
            resp_err !== e_err || req_ack !== 4'b0 || set_en !== 1'b0) begin
          n_err++;
          $display("FAIL backpressure_hold: valid=%b id=%0d cand=%h err=%b ack=%b en=%b, expected 1/%0d/%h/%b/0000/0",
                   resp_valid, resp_id, resp_candidate, resp_err, req_ack, set_en, ge, e_cand, e_err);
        end
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    m_jobs = (m_jobs + 1) & 16'hFFFF;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ack !== 4'b0 || jobs_done !== 16'(m_jobs)) begin
      n_err++;
      $display("FAIL accept: valid=%b ack=%b jobs_done=%0d, expected 0/0000/%0d", resp_valid, req_ack, jobs_done, m_jobs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; set_busy = 1'b0; resp_ready = 1'b1;
    core_lat = 0; core_cand = '0;
    for (int i = 0; i < 4; i++) begin f_cen[i] = '0; f_rad[i] = '0; f_mode[i] = '0; end
    drive_fields();
    m_ptr = 0; m_jobs = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (req_ack !== 4'b0 || set_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ack=%b en=%b valid=%b, expected all 0", req_ack, set_en, resp_valid);
    end
    n_vec++;
    if ({set_central, set_radius, set_mode} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_set_fields: got %h, expected 0", {set_central, set_radius, set_mode});
    end
    n_vec++;
    if ({resp_id, resp_candidate, resp_err, jobs_done} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_resp: id=%0d cand=%h err=%b jobs=%0d, expected 0", resp_id, resp_candidate, resp_err, jobs_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int g;
    f_cen[2] = 24'h443322; f_rad[2] = 12'h443; f_mode[2] = 2'b10;
    drive_fields();
    req = 4'b0100;
    serve(5, 8'd17, 0, 1'b1, 4'b0, g);
    n_vec++;
    if (g !== 2 || jobs_done !== 16'd1) begin
      n_err++;
      $display("FAIL single_job: granted %0d jobs_done=%0d, expected 2 and 1", g, jobs_done);
    end
  endtask

  task automatic test_order();
    int g;
    int exp_order[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; m_ptr = 0; m_jobs = 0;
    for (int i = 0; i < 4; i++) begin f_cen[i] = 24'($urandom); f_rad[i] = 12'($urandom); f_mode[i] = 2'($urandom); end
    drive_fields();
    req = 4'b1111;
    for (int j = 0; j < 9; j++) begin
      serve(1, 8'(8'h40 + j), 0, 1'b0, (j == 4) ? 4'b0010 : (j == 8) ? 4'b1111 : 4'b0000, g);
      n_vec++;
      if (g !== exp_order[j]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: granted %0d, expected %0d", j, g, exp_order[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    req = 4'b1010;
    serve(3, 8'h9C, 6, 1'b1, 4'b0, g);
    serve(2, 8'h21, 0, 1'b1, 4'b0, g);
  endtask

  task automatic test_timeout();
    int g1, g2;
    req = 4'b0011;
    serve(0, 8'hAA, 0, 1'b1, 4'b0, g1);
    serve(3, 8'h77, 0, 1'b1, 4'b0, g2);
    n_vec++;
    if (g2 === g1 || g2 < 0) begin
      n_err++;
      $display("FAIL timeout_next_grant: second grant %0d, expected the other requester than %0d", g2, g1);
    end
    req = 4'b0100;
    serve(16, 8'h5A, 0, 1'b1, 4'b0, g1);
  endtask

  task automatic test_busy();
    int g;
    set_busy = 1'b1;
    req = 4'b0001;
    repeat (10) begin
      @(negedge clk);
      n_vec++;
      if (req_ack !== 4'b0 || set_en !== 1'b0) begin
        n_err++;
        $display("FAIL busy_hold: ack=%b en=%b while set_busy, expected 0000/0", req_ack, set_en);
      end
    end
    set_busy = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ack !== 4'b0001) begin
      n_err++;
      $display("FAIL busy_release: ack=%b one cycle after set_busy fell, expected 0001", req_ack);
    end
    serve(4, 8'h3C, 0, 1'b1, 4'b0, g);
  endtask

  task automatic test_random();
    int g, lat;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          f_cen[i] = 24'($urandom); f_rad[i] = 12'($urandom); f_mode[i] = 2'($urandom);
          req[i] = 1'b1;
        end
      end
      if (req == 4'b0) req[$urandom_range(0, 3)] = 1'b1;
      drive_fields();
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      serve(lat, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'b0, g);
    end
  endtask

  task automatic test_midreset();
    int n, g;
    req = 4'b1000; core_lat = 0;
    n = 0;
    while (req_ack === 4'b0 && n < 40) begin @(negedge clk); n++; end
    n_vec++;
    if (req_ack !== 4'b1000) begin
      n_err++;
      $display("FAIL midreset_grant: ack=%b, expected 1000", req_ack);
    end
    req = 4'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({req_ack, set_en, set_central, set_radius, set_mode, resp_valid, resp_id,
         resp_candidate, resp_err, jobs_done} !== 70'h0) begin
      n_err++;
      $display("FAIL async_reset: ack=%b en=%b fields=%h valid=%b id=%0d cand=%h err=%b jobs=%0d, expected all 0",
               req_ack, set_en, {set_central, set_radius, set_mode}, resp_valid, resp_id,
               resp_candidate, resp_err, jobs_done);
    end
    @(negedge clk);
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b1; m_ptr = 0; m_jobs = 0;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ack !== 4'b0) begin
      n_err++;
      $display("FAIL reset_drop: valid=%b ack=%b during reset, expected 0/0000", resp_valid, req_ack);
    end
    serve(2, 8'h33, 0, 1'b1, 4'b0110, g);
    n_vec++;
    if (g !== 1) begin
      n_err++;
      $display("FAIL post_reset_grant: granted %0d, expected 1", g);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_backpressure();
    test_timeout();
    test_busy();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
